// File: rtl/siso_stream_ctrl.sv
// siso_stream_ctrl: serialises one word into an external free-running SISO
// buffer, LSB first, and reassembles the returned bits into an output word.
// Exactly one word is in flight at a time; a valid delay line tracks which
// buffer outputs carry launched bits so stale buffer contents are ignored.
module siso_stream_ctrl #(
  parameter int WORD_W  = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ser_out,
  input  logic              ser_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RX_W  = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, TX, FLUSH, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [RX_W-1:0]   rx_cnt;
  logic [WORD_W-1:0] tx_word;
  logic [WORD_W-1:0] rx_word;
  logic [WORD_W-1:0] rx_shifted;
  logic [LATENCY-1:0] vld_pipe;

  logic accept;
  logic launch;
  logic tap;
  logic last_bit;
  logic last_capture;
  logic handshake;

  // The launch signal is the first position of the delay line; vld_pipe adds
  // LATENCY registered positions so its top bit lines up with ser_in.
  assign accept       = s_valid & s_ready;
  assign launch       = (state == TX);
  assign tap          = vld_pipe[LATENCY-1];
  assign last_bit     = (bit_cnt == BIT_W'(WORD_W - 1));
  assign last_capture = tap && (rx_cnt == RX_W'(WORD_W - 1));
  assign handshake    = (state == DONE) && m_valid && m_ready;
  assign rx_shifted   = {ser_in, rx_word[WORD_W-1:1]};

  // State register; clear aborts back to IDLE from anywhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)       state_next = TX;
      TX:      if (last_bit)     state_next = FLUSH;
      FLUSH:   if (last_capture) state_next = DONE;
      DONE:    if (handshake)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore-style outputs; s_ready is also gated by reset and clear
  always_comb begin
    s_ready = rst && !clear && (state == IDLE);
    busy    = (state != IDLE);
    ser_out = launch ? tx_word[bit_cnt] : 1'b0;
  end

  // Transmit side: latch the accepted word and walk the bit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_word <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      tx_word <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      tx_word <= s_data;
      bit_cnt <= '0;
    end else if (launch) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  // Valid delay line mirroring the buffer's fixed latency
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_vld
      // One stage of the launched-bit tracker
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       vld_pipe[gi] <= 1'b0;
        else if (clear) vld_pipe[gi] <= 1'b0;
        else if (gi == 0) vld_pipe[gi] <= launch;
        else            vld_pipe[gi] <= vld_pipe[(gi > 0) ? gi - 1 : 0];
      end
    end
  endgenerate

  // Receive side: capture only tracked bits, shift right so bit 0 ends at LSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_word <= '0;
      rx_cnt  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (clear) begin
      rx_word <= '0;
      rx_cnt  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (tap) begin
        if (last_capture) begin
          rx_word <= '0;
          rx_cnt  <= '0;
          m_data  <= rx_shifted;
          m_valid <= 1'b1;
        end else begin
          rx_word <= rx_shifted;
          rx_cnt  <= rx_cnt + 1'b1;
        end
      end
      if (handshake) m_valid <= 1'b0;
    end
  end

  // Completed-handshake counter; wraps naturally, survives clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     word_count <= '0;
    else if (!clear && handshake) word_count <= word_count + 1'b1;
  end

endmodule

// File: doc/siso_stream_ctrl.md
SISO_STREAM_CTRL -- requirements
Module: siso_stream_ctrl

Interface
REQ-001 Parameter WORD_W, default 32, meaning word width and serial bits per transfer.
REQ-002 Parameter LATENCY, default 2, meaning register stages from ser_out to ser_in through the attached free-running SISO buffer.
REQ-003 Parameter CNT_W, default 16, meaning width of the completed-word counter.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-006 clear  input  1  synchronous abort, active-high.
REQ-007 s_valid  input  1  input word offered.
REQ-008 s_ready  output  1  controller accepts word this cycle.
REQ-009 s_data  input  WORD_W  word to pass through the buffer.
REQ-010 ser_out  output  1  serial bit driven to the buffer input.
REQ-011 ser_in  input  1  serial bit returned from the buffer output.
REQ-012 m_valid  output  1  reassembled word available.
REQ-013 m_ready  input  1  downstream accepts word.
REQ-014 m_data  output  WORD_W  reassembled word.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 word_count  output  CNT_W  number of completed output handshakes.

Function
REQ-017 The FSM SHALL have states IDLE, TX, FLUSH, DONE.
REQ-018 s_ready SHALL be 1 only in IDLE with clear=0; acceptance = s_valid&s_ready at a rising edge (edge E0).
REQ-019 On acceptance, s_data SHALL be latched into tx_word, bit_cnt cleared, state -> TX.
REQ-020 In TX, ser_out SHALL equal tx_word[bit_cnt], LSB first; bit_cnt increments each cycle; after bit WORD_W-1 is driven, state -> FLUSH.
REQ-021 Outside TX, ser_out SHALL be 0.
REQ-022 The buffer has no enable, so a LATENCY+1-deep valid delay line SHALL track launched bits; ser_in is captured only when its tap is 1.
REQ-023 Bit k (driven in the cycle after edge E_k) SHALL be captured at edge E_(k+LATENCY+1), shifting right into rx_word MSB so bit 0 ends at rx_word[0].
REQ-024 FLUSH SHALL persist until the last bit is captured; at that edge m_data <= rx_word-complete, m_valid <= 1, state -> DONE (m_valid first high after E_(WORD_W+LATENCY); after E_34 at defaults).
REQ-025 In DONE, m_valid and m_data SHALL hold stable until m_valid&m_ready; at that edge m_valid <= 0, word_count increments, state -> IDLE.
REQ-026 word_count SHALL wrap modulo 2^CNT_W without saturation.
REQ-027 Only one word SHALL be in flight; no new acceptance before DONE handshake completes (throughput one word per WORD_W+LATENCY+2 cycles minimum).
REQ-028 clear=1 at any edge SHALL force IDLE, m_valid=0, bit_cnt=0, valid delay line=0, tx_word/rx_word=0; word_count is retained; clear overrides a simultaneous s_valid or m_ready handshake (no acceptance, no count).
REQ-029 ser_in SHALL be ignored whenever the delay-line tap is 0 (stale buffer contents after clear/reset never enter rx_word).
REQ-030 m_ready asserted while m_valid=0 SHALL have no effect.

Reset
REQ-031 rst=0 SHALL immediately set state IDLE, s_ready per REQ-018 (0 while rst=0), ser_out=0, m_valid=0, m_data=0, busy=0, word_count=0, all counters, delay line and word registers 0.
REQ-032 Reset asserted mid-TX/FLUSH/DONE SHALL discard the word in flight; after release operation restarts from IDLE with no spurious m_valid.

Verification
REQ-033 Reset release, s_data=32'hA5A5_0F0F, m_ready=1 -> ser_out LSB-first over 32 cycles, m_valid after E_34, m_data=32'hA5A5_0F0F, word_count=1.
REQ-034 Word 32'hFFFF_FFFF, m_ready=0 for 10 cycles after m_valid -> m_valid/m_data held, s_ready=0 throughout, count increments only at handshake.
REQ-035 Back-to-back words 32'h0000_0001 then 32'h8000_0000 with s_valid held -> second accepted only in IDLE after first handshake; both outputs exact, word_count=2.
REQ-036 clear pulsed at bit 15 of TX for 32'h1234_5678 -> IDLE next edge, no m_valid; next word 32'hDEAD_BEEF returns exact (no stale bits).
REQ-037 rst=0 asynchronously during FLUSH -> all outputs 0 without a clock edge; post-release word 32'hCAFE_F00D returns exact.
REQ-038 CNT_W=4, 17 handshakes -> word_count=1 (wrap).
